qpoint_spike_accumulator: RTL
=============================

QPOINT_SPIKE_ACCUMULATOR -- requirements
Module: qpoint_spike_accumulator

Interface
REQ-001 Parameter INP_WIDTH, default 8: weight word width, signed two's complement.
REQ-002 Parameter FRAC_BITS, default 7: fractional bits of weights and sum (Q format shared).
REQ-003 Parameter DEPTH, default 125: number of weights / synapses.
REQ-004 Parameter OUT_WIDTH, default 16: accumulator/sum width, signed, >= INP_WIDTH+1.
REQ-005 Parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 wr_en  input  1  weight write strobe.
REQ-009 wr_addr  input  clog2(DEPTH)  weight write address.
REQ-010 wr_data  input  INP_WIDTH  signed weight value.
REQ-011 spike_in  input  DEPTH  spike vector; bit i gates weight i.
REQ-012 start  input  1  begin accumulation pass.
REQ-013 busy  output  1  high while a pass is in progress.
REQ-014 done  output  1  one-cycle pulse; sum valid.
REQ-015 sum  output  OUT_WIDTH  signed accumulated result, held until next start.
REQ-016 sat_flag  output  1  high if any add in the last pass saturated (or wrapped when SATURATE=0).

Function
REQ-017 FSM states IDLE, ACCUM, DONE; IDLE->ACCUM on start; ACCUM->DONE after index DEPTH-1; DONE->IDLE unconditionally.
REQ-018 On start in IDLE: spike_in latched, accumulator and sat_flag cleared, index cleared to 0, busy set next cycle.
REQ-019 ACCUM: one weight per cycle, index 0..DEPTH-1; acc += sign-extended weight[index] if latched spike bit set, else acc unchanged.
REQ-020 Latency: start sampled at edge T -> done high during cycle after edge T+DEPTH+1; sum valid same cycle, held thereafter.
REQ-021 start while busy or in DONE: ignored, no restart, no error.
REQ-022 wr_en while busy: ignored (weight memory unchanged); in IDLE/DONE: write at next edge; wr_addr >= DEPTH ignored.
REQ-023 Same-edge wr_en and start in IDLE: write completes; pass uses the new weight.
REQ-024 SATURATE=1: result > 2^(OUT_WIDTH-1)-1 clamps to max, < -2^(OUT_WIDTH-1) clamps to min; sat_flag set, sticky for the pass.
REQ-025 SATURATE=0: wrap modulo 2^OUT_WIDTH; sat_flag still set on overflow.
REQ-026 All-zero spike vector: sum = 0, sat_flag = 0, latency unchanged.
REQ-027 Weight memory contents unaffected by start; undefined until written.

Reset
REQ-028 rst asserted: FSM -> IDLE, busy=0, done=0, sum=0, sat_flag=0, index=0, immediately (asynchronously).
REQ-029 rst mid-pass aborts the pass; no done pulse; weight memory contents not cleared.
REQ-030 Release of rst: first start honoured on the first edge after deassertion.

Structure
REQ-031 Shared package qpoint_pkg holds FSM state encoding and saturation min/max helper constants.
REQ-032 Sub-module qpoint_sat_add (parametrised INP_WIDTH, OUT_WIDTH, SATURATE): combinational add with overflow flag, reusable by the existing adder path.
REQ-033 Weight memory inferred as register array inside qpoint_spike_accumulator; no file loading in RTL.

Verification (DEPTH=4, INP_WIDTH=8, FRAC_BITS=7, OUT_WIDTH=10 unless noted)
REQ-034 Weights 0x40,0x20,0x10,0x08 (0.5,0.25,0.125,0.0625), spikes 4'b1111, start -> done 5 cycles after start edge, sum=0x078 (0.9375), sat_flag=0.
REQ-035 Same weights, spikes 4'b0101 -> sum=0x050 (0.625); spikes 4'b0000 -> sum=0, done at same latency.
REQ-036 OUT_WIDTH=9, weights all 0x7F, spikes 4'b1111: SATURATE=1 -> sum=0x0FF, sat_flag=1; SATURATE=0 -> sum=0x1FC (wrapped), sat_flag=1.
REQ-037 Weights all 0x80 (-1.0), OUT_WIDTH=9, SATURATE=1 -> sum=0x100 (min), sat_flag=1.
REQ-038 start and wr_en(addr 2, 0x7F) pulsed during ACCUM -> both ignored; sum equals pre-pass expectation; later pass reflects no write.
REQ-039 rst asserted two cycles into a pass -> busy, done, sum, sat_flag 0 asynchronously; no done pulse; new start afterwards yields correct sum with retained weights.

Source files
------------

// File: rtl/qpoint_pkg.sv
// Shared definitions for the spike accumulator: FSM encoding and saturation bounds.
package qpoint_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Widest supported sum; narrower bounds are taken as the top bits of these.
  localparam int unsigned MaxWidth = 64;
  localparam logic [MaxWidth-1:0] SatMaxFull = {1'b0, {(MaxWidth-1){1'b1}}};
  localparam logic [MaxWidth-1:0] SatMinFull = {1'b1, {(MaxWidth-1){1'b0}}};

endpackage

// File: rtl/qpoint_sat_add.sv
// Combinational signed add of a narrow word into a wide sum, with clamp-or-wrap on overflow.
module qpoint_sat_add
  import qpoint_pkg::*;
#(
  parameter int unsigned INP_WIDTH = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic [OUT_WIDTH-1:0] acc_i,
  input  logic [INP_WIDTH-1:0] add_i,
  output logic [OUT_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  localparam logic [OUT_WIDTH-1:0] SatMax = SatMaxFull[MaxWidth-1 -: OUT_WIDTH];
  localparam logic [OUT_WIDTH-1:0] SatMin = SatMinFull[MaxWidth-1 -: OUT_WIDTH];

  logic [OUT_WIDTH:0] ext_sum;

  // One guard bit is enough: the addend is always narrower than the sum.
  assign ext_sum = {acc_i[OUT_WIDTH-1], acc_i}
                 + {{(OUT_WIDTH + 1 - INP_WIDTH){add_i[INP_WIDTH-1]}}, add_i};
  assign ovf_o   = ext_sum[OUT_WIDTH] ^ ext_sum[OUT_WIDTH-1];

  always_comb begin
    sum_o = ext_sum[OUT_WIDTH-1:0];
    if (SATURATE && ovf_o) begin
      sum_o = ext_sum[OUT_WIDTH] ? SatMin : SatMax;
    end
  end

endmodule

// File: rtl/qpoint_spike_accumulator.sv
// Spike-gated weight accumulator: one synapse per cycle into a signed Q-format sum.
module qpoint_spike_accumulator
  import qpoint_pkg::*;
#(
  parameter int unsigned INP_WIDTH = 8,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned DEPTH     = 125,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          SATURATE  = 1'b1,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [INP_WIDTH-1:0] wr_data,
  input  logic [DEPTH-1:0]     spike_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] sum,
  output logic                 sat_flag
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  state_e                 state_q;
  logic [AW-1:0]          idx_q;
  logic [DEPTH-1:0]       spikes_q;
  logic [OUT_WIDTH-1:0]   acc_q;
  logic [INP_WIDTH-1:0]   mem [DEPTH];
  logic [INP_WIDTH-1:0]   gated_w;
  logic [OUT_WIDTH-1:0]   add_sum;
  logic                   add_ovf;

  // Weight memory has no reset so a mid-pass reset leaves trained weights intact.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q != StAccum) && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign gated_w = spikes_q[idx_q] ? mem[idx_q] : '0;

  qpoint_sat_add #(
    .INP_WIDTH (INP_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_add (
    .acc_i (acc_q),
    .add_i (gated_w),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      spikes_q <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      sat_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            spikes_q <= spike_in;
            acc_q    <= '0;
            sat_flag <= 1'b0;
            idx_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= add_sum;
          if (add_ovf) begin
            sat_flag <= 1'b1;
          end
          if (idx_q == LastIdx) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          sum     <= acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
